accum_diff: RTL and testbench

- Inverse of the team's running-sum accumulator: consumes a stream of accumulated sums and recovers the per-cycle increments, delta[n] = sum[n] - sum[n-1] mod 2^WIDTH.
- Sits on the readback/check side of the accumulator datapath, so captured accumulator output can be decoded back to the original D stream.
- Valid/ready on both sides.
- Registered output through a 2-entry skid buffer, so s_ready is a flop and does not depend combinationally on m_ready.

---
 rtl/accum_pkg.sv | 20 ++
 rtl/accum_diff_skid.sv | 72 +++++++
 rtl/accum_diff.sv | 104 ++++++++++
 tb/tb_accum_diff.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types for the accumulator datapath and its readback decoder.
//   ACCUM_WIDTH  : default sum/delta width
//   accum_t      : one accumulator sample
//   diff_entry_t : decoded delta plus "first after reset/resync" tag
//   ST_FIRST/ST_RUN : decoder state encodings
package accum_pkg;

  localparam int unsigned ACCUM_WIDTH = 8;

  typedef logic [ACCUM_WIDTH-1:0] accum_t;

  typedef struct packed {
    accum_t delta;
    logic   first;
  } diff_entry_t;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/accum_diff_skid.sv
// Generic 2-entry valid/ready skid buffer with a registered input ready.
//   clk, reset       : clock, synchronous active-high reset (flushes contents)
//   i_valid/o_ready  : upstream handshake; o_ready is a flop
//   i_data           : entry to store
//   o_valid/i_ready  : downstream handshake; head is presented on o_data
//   o_data           : head entry, held stable while stalled
module accum_diff_skid
  import accum_pkg::*;
#(
  parameter type T = diff_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  logic [1:0] r_occ;
  logic [1:0] w_occ_nxt;
  logic       r_ready;
  T           r_e0;
  T           r_e1;
  logic       w_push;
  logic       w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = (r_occ != 2'd0) & i_ready;
  assign o_ready = r_ready;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_e0;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + 2'd1;
    else if (!w_push && w_pop) w_occ_nxt = r_occ - 2'd1;
  end

  // r_e0 is always the head; r_e1 only holds data when two entries are queued.
  // Ready is computed from the next occupancy so it drops on the cycle the
  // buffer is full, which keeps a push from ever landing on a full buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ   <= '0;
      r_ready <= 1'b0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt != 2'd2);
      case (r_occ)
        2'd0: begin
          if (w_push) r_e0 <= i_data;
        end
        2'd1: begin
          if (w_push && w_pop) r_e0 <= i_data;
          else if (w_push)     r_e1 <= i_data;
        end
        default: begin
          if (w_pop) begin
            r_e0 <= r_e1;
            if (w_push) r_e1 <= i_data;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/accum_diff.sv
// Running-sum decoder: recovers per-sample increments from accumulated sums,
// delta = s_sum - previous sum (mod 2^WIDTH), output through a 2-entry skid.
//   clk, reset         : clock, synchronous active-high reset
//   s_valid/s_ready    : input handshake (s_ready is registered)
//   s_sum              : accumulated sum sample
//   s_resync           : restart reference from INIT for this accepted sample
//   m_valid/m_ready    : output handshake
//   m_delta, m_first   : recovered increment, first-after-reset/resync tag
// Optional (ACCUM_DIFF_CNT_EN):
//   m_count            : deltas popped since reset/resync, carried by the head
//   m_zero             : head delta is zero
module accum_diff
  import accum_pkg::*;
#(
  parameter int unsigned      WIDTH = ACCUM_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic             s_resync,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_delta,
`ifdef ACCUM_DIFF_CNT_EN
  output logic [15:0]      m_count,
  output logic             m_zero,
`endif
  output logic             m_first
);

  typedef struct packed {
    logic [WIDTH-1:0] delta;
    logic             first;
`ifdef ACCUM_DIFF_CNT_EN
    logic [15:0]      count;
`endif
  } entry_t;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_prev;
  logic             w_accept;
  logic             w_first;
  logic [WIDTH-1:0] w_ref;
  entry_t           w_in;
  entry_t           w_out;
  logic             w_s_ready;

  assign w_accept = s_valid & w_s_ready;
  assign w_first  = (r_state == ST_FIRST) | s_resync;
  assign w_ref    = w_first ? INIT : r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FIRST;
      r_prev  <= INIT;
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_prev  <= s_sum;
    end
  end

`ifdef ACCUM_DIFF_CNT_EN
  // The count is tagged at push time: entries leave in order, so the number
  // pushed before an entry since the last first is exactly the number popped
  // before it by the time it reaches the head.
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_tag;

  assign w_cnt_tag = w_first ? 16'd0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_accept) r_cnt <= w_cnt_tag + 16'd1;
  end

  assign w_in.count = w_cnt_tag;
  assign m_count    = w_out.count;
  assign m_zero     = (w_out.delta == '0);
`endif

  assign w_in.delta = s_sum - w_ref;
  assign w_in.first = w_first;

  accum_diff_skid #(
    .T (entry_t)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (s_valid),
    .o_ready (w_s_ready),
    .i_data  (w_in),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (w_out)
  );

  assign s_ready = w_s_ready;
  assign m_delta = w_out.delta;
  assign m_first = w_out.first;

endmodule

// File: tb/tb_accum_diff.sv
module tb_accum_diff;

  localparam logic [7:0] INIT = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_sum;
  logic       s_resync;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_delta;
  logic       m_first;
`ifdef ACCUM_DIFF_CNT_EN
  logic [15:0] m_count;
  logic        m_zero;
`endif

  always #5 clk = ~clk;

  accum_diff #(
    .WIDTH (8),
    .INIT  (INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sum    (s_sum),
    .s_resync (s_resync),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_delta  (m_delta),
`ifdef ACCUM_DIFF_CNT_EN
    .m_count  (m_count),
    .m_zero   (m_zero),
`endif
    .m_first  (m_first)
  );

  typedef struct {
    logic [7:0]  delta;
    logic        first;
    logic [15:0] count;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  bit          lat1_chk = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          done = 1'b0;

  // reference model: previous sum, whether the next sample starts a new run,
  // and how many deltas have been produced in the current run
  logic [7:0]  mdl_prev;
  bit          mdl_fresh;
  logic [15:0] mdl_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    mdl_prev  = INIT;
    mdl_fresh = 1'b1;
    mdl_cnt   = 16'd0;
  endtask

  task automatic model_accept(input logic [7:0] sum, input logic resync);
    exp_t e;
    logic [7:0] refv;
    e.first = mdl_fresh || resync;
    refv    = e.first ? INIT : mdl_prev;
    e.delta = sum - refv;
    e.count = e.first ? 16'd0 : mdl_cnt;
    e.cyc   = cyc;
    mdl_cnt   = e.count + 16'd1;
    mdl_prev  = sum;
    mdl_fresh = 1'b0;
    sbq.push_back(e);
  endtask

  // monitor: observes both handshakes on the falling edge
  task automatic monitor();
    bit         stall_prev = 1'b0;
    logic [7:0] hold_delta = '0;
    logic       hold_first = 1'b0;
    exp_t       e;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        model_reset();
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev && m_valid) begin
        check("hold_delta", 32'(m_delta), 32'(hold_delta));
        check("hold_first", 32'(m_first), 32'(hold_first));
      end
      stall_prev = m_valid && !m_ready;
      hold_delta = m_delta;
      hold_first = m_first;
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'(m_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("delta", 32'(m_delta), 32'(e.delta));
          check("first", 32'(m_first), 32'(e.first));
`ifdef ACCUM_DIFF_CNT_EN
          check("count", 32'(m_count), 32'(e.count));
          check("zero", 32'(m_zero), 32'(e.delta == 8'h00));
`endif
          if (lat1_chk) check("latency", cyc - e.cyc, 32'd1);
        end
      end
      if (s_valid && s_ready) model_accept(s_sum, s_resync);
    end
  endtask

  task automatic cycle_step();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] sum, input logic resync);
    int n = 0;
    bit ok;
    s_valid  = 1'b1;
    s_sum    = sum;
    s_resync = resync;
    forever begin
      @(negedge clk);
      ok = s_ready;
      cycle_step();
      if (ok) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    s_valid  = 1'b0;
    s_resync = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_sum    = 8'($urandom);
      s_resync = 1'($urandom);
      cycle_step();
    end
    s_resync = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while ((sbq.size() != 0 || m_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
    cycle_step();
  endtask

  task automatic drive();
    logic [7:0] bp[4];
    int idx;
    bit acc;
    logic [7:0] last;

    reset = 1'b1; s_valid = 1'b0; s_sum = '0; s_resync = 1'b0; m_ready = 1'b0;
    repeat (3) cycle_step();
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_delta", 32'(m_delta), 32'd0);
    check("rst_m_first", 32'(m_first), 32'd0);
    cycle_step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    cycle_step();

    // basic decode and wrap-around with an always-ready sink
    lat1_chk = 1'b1;
    m_ready  = 1'b1;
    send(8'h05, 1'b0); send(8'h0C, 1'b0); send(8'h0A, 1'b0);
    idle(2);
    send(8'hF0, 1'b1); send(8'h10, 1'b0); send(8'h10, 1'b0);
    idle(2);
    // resync mid-stream
    send(8'h03, 1'b1); send(8'h08, 1'b0); send(8'h20, 1'b1); send(8'h21, 1'b0);
    idle(3);
    lat1_chk = 1'b0;

    // backpressure: only two samples fit while the sink is stalled
    bp[0] = 8'h30; bp[1] = 8'h31; bp[2] = 8'h40; bp[3] = 8'h50;
    m_ready = 1'b0;
    idx = 0;
    s_valid = 1'b1;
    s_sum = bp[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = s_ready;
      cycle_step();
      if (acc) begin idx++; s_sum = bp[idx]; end
    end
    @(negedge clk);
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_s_ready", 32'(s_ready), 32'd0);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    cycle_step();
    m_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      acc = s_ready;
      cycle_step();
      if (acc) begin idx++; if (idx < 4) s_sum = bp[idx]; end
    end
    s_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd4);
    drain();

    // reset with two deltas buffered
    m_ready = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    idle(1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    cycle_step();
    reset = 1'b0;
    m_ready = 1'b1;
    lat1_chk = 1'b1;
    send(8'h07, 1'b0);
    idle(3);
    lat1_chk = 1'b0;

    // count behaviour: three deltas, then a resync sample, then a repeat
    send(8'h05, 1'b1); send(8'h06, 1'b0); send(8'h07, 1'b0);
    send(8'h09, 1'b1); send(8'h09, 1'b0);
    idle(3);

    // randomized traffic with a randomly stalling sink
    rnd_ready = 1'b1;
    last = 8'h00;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 5) == 0) ? last : 8'($urandom);
      send(v, 1'($urandom_range(0, 7) == 0));
      last = v;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rnd_ready = 1'b0;
    drain();
    done = 1'b1;
  endtask

  initial begin
    model_reset();
    fork
      drive();
      monitor();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
